wb_stage: RTL and testbench

//  Write-back stage of the RV32I pipeline, directly downstream of the memory-access stage.
//  - Aligns and sign/zero-extends load data.
//  - Selects load data or ALU result and drives the register-file write port.
//  - Holds a one-entry bypass register of the last write, for the decode stage.
//  - Keeps the 64-bit retired-instruction counter (instret).

---
 rtl/wb_stage.sv | 100 ++++++++++
 tb/tb_wb_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: load alignment, register-file write port, one-entry bypass register, instret counter.
// Latency: write port is combinational (zero cycles); bypass entry and instret update on the next clk edge.
// Backpressure: none generated; a high stall simply suppresses the write and the retire count.
module wb_stage #(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_ld_wb,
    input  logic [2:0]           ld_code_wb,
    input  logic [4:0]           rd_adr_wb,
    input  logic [31:0]          rd_data_wb,
    input  logic                 wbk_rd_reg_wb,
    input  logic [31:0]          ld_data_wb,
    input  logic                 retire_wb,
    input  logic                 stall,
    input  logic                 rst_pipe,
    output logic                 wbk_en,
    output logic [4:0]           wbk_adr,
    output logic [31:0]          wbk_data,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_adr,
    output logic [31:0]          fwd_data,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    logic [1:0]  ld_ofs;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_aligned;
    logic        retire_ok;

    // For loads the ALU result carries the byte address; its low bits pick the lane.
    assign ld_ofs = rd_data_wb[1:0];

    // Extract the addressed byte and halfword lanes from the raw RAM word.
    always_comb begin
        ld_byte = ld_data_wb[7:0];
        case (ld_ofs)
            2'd0: ld_byte = ld_data_wb[7:0];
            2'd1: ld_byte = ld_data_wb[15:8];
            2'd2: ld_byte = ld_data_wb[23:16];
            2'd3: ld_byte = ld_data_wb[31:24];
            default: ld_byte = ld_data_wb[7:0];
        endcase
        // Halfword lane depends only on address bit 1; a misaligned bit 0 is ignored.
        ld_half = rd_data_wb[1] ? ld_data_wb[31:16] : ld_data_wb[15:0];
    end

    // Sign- or zero-extend the selected lane according to funct3; unused codes read as zero.
    always_comb begin
        ld_aligned = 32'd0;
        case (ld_code_wb)
            LD_LB:   ld_aligned = {{24{ld_byte[7]}}, ld_byte};
            LD_LH:   ld_aligned = {{16{ld_half[15]}}, ld_half};
            LD_LW:   ld_aligned = ld_data_wb;
            LD_LBU:  ld_aligned = {24'd0, ld_byte};
            LD_LHU:  ld_aligned = {16'd0, ld_half};
            default: ld_aligned = 32'd0;
        endcase
    end

    // Register-file write port; a stalled instruction writes only once the stall lifts.
    always_comb begin
        wbk_adr  = rd_adr_wb;
        wbk_data = cmd_ld_wb ? ld_aligned : rd_data_wb;
        wbk_en   = wbk_rd_reg_wb & ~stall & ~rst_pipe & ~rst & (rd_adr_wb != 5'd0);
    end

    // Bypass entry mirrors the last RF write so decode can read it in the following cycle.
    always_ff @(posedge clk) begin
        if (rst || rst_pipe) begin
            fwd_valid <= 1'b0;
            fwd_adr   <= 5'd0;
            fwd_data  <= 32'd0;
        end else if (wbk_en) begin
            fwd_valid <= 1'b1;
            fwd_adr   <= wbk_adr;
            fwd_data  <= wbk_data;
        end
    end

    assign retire_ok = retire_wb & ~stall & ~rst_pipe;

    // Retired-instruction count; survives pipeline flushes and wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (retire_ok) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_ld_wb;
    logic [2:0]  ld_code_wb;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb;
    logic        wbk_rd_reg_wb;
    logic [31:0] ld_data_wb;
    logic        retire_wb;
    logic        stall;
    logic        rst_pipe;

    logic        wbk_en,  s_wbk_en;
    logic [4:0]  wbk_adr, s_wbk_adr;
    logic [31:0] wbk_data, s_wbk_data;
    logic        fwd_valid, s_fwd_valid;
    logic [4:0]  fwd_adr, s_fwd_adr;
    logic [31:0] fwd_data, s_fwd_data;
    logic [63:0] instret;
    logic [2:0]  s_instret;

    // Reference state, updated once per clock from the behavioural rules.
    logic        m_fwd_valid;
    logic [4:0]  m_fwd_adr;
    logic [31:0] m_fwd_data;
    logic [63:0] m_instret;
    int unsigned m_small;

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;

    always #5 clk = ~clk;

    wb_stage #(.INSTRET_W(64)) u_dut (
        .clk(clk), .rst(rst), .cmd_ld_wb(cmd_ld_wb), .ld_code_wb(ld_code_wb),
        .rd_adr_wb(rd_adr_wb), .rd_data_wb(rd_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
        .ld_data_wb(ld_data_wb), .retire_wb(retire_wb), .stall(stall), .rst_pipe(rst_pipe),
        .wbk_en(wbk_en), .wbk_adr(wbk_adr), .wbk_data(wbk_data),
        .fwd_valid(fwd_valid), .fwd_adr(fwd_adr), .fwd_data(fwd_data), .instret(instret)
    );

    // Narrow-counter instance so the wrap from all-ones to zero is reachable in a short run.
    wb_stage #(.INSTRET_W(3)) u_small (
        .clk(clk), .rst(rst), .cmd_ld_wb(cmd_ld_wb), .ld_code_wb(ld_code_wb),
        .rd_adr_wb(rd_adr_wb), .rd_data_wb(rd_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
        .ld_data_wb(ld_data_wb), .retire_wb(retire_wb), .stall(stall), .rst_pipe(rst_pipe),
        .wbk_en(s_wbk_en), .wbk_adr(s_wbk_adr), .wbk_data(s_wbk_data),
        .fwd_valid(s_fwd_valid), .fwd_adr(s_fwd_adr), .fwd_data(s_fwd_data), .instret(s_instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected load result computed arithmetically from the instruction semantics.
    function automatic logic [31:0] ref_load(input logic [2:0] code, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * addr[1:0])) % 256;
        h = (word >> (16 * addr[1])) % 65536;
        case (code)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b010:  return word;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic ld, input logic [2:0] code, input logic [4:0] rd,
                         input logic [31:0] data, input logic wr, input logic [31:0] ldd,
                         input logic ret, input logic stl, input logic rp, input logic r);
        cmd_ld_wb = ld; ld_code_wb = code; rd_adr_wb = rd; rd_data_wb = data;
        wbk_rd_reg_wb = wr; ld_data_wb = ldd; retire_wb = ret; stall = stl;
        rst_pipe = rp; rst = r;
    endtask

    // One clock: check the combinational port mid-cycle, then the registered state after the edge.
    task automatic cycle();
        logic [31:0] e_data;
        logic        e_en;
        @(negedge clk);
        #1;
        e_data = cmd_ld_wb ? ref_load(ld_code_wb, rd_data_wb, ld_data_wb) : rd_data_wb;
        e_en   = wbk_rd_reg_wb && !stall && !rst_pipe && !rst && (rd_adr_wb != 0);
        chk("wbk_en", {63'd0, wbk_en}, {63'd0, e_en});
        chk("wbk_adr", {59'd0, wbk_adr}, {59'd0, rd_adr_wb});
        chk("wbk_data", {32'd0, wbk_data}, {32'd0, e_data});
        chk("small_wbk_en", {63'd0, s_wbk_en}, {63'd0, e_en});
        if (e_en) n_writes++;
        if (rst) begin
            m_fwd_valid = 1'b0; m_fwd_adr = 5'd0; m_fwd_data = 32'd0;
            m_instret = 64'd0; m_small = 0;
        end else begin
            if (rst_pipe) begin
                m_fwd_valid = 1'b0; m_fwd_adr = 5'd0; m_fwd_data = 32'd0;
            end else if (e_en) begin
                m_fwd_valid = 1'b1; m_fwd_adr = rd_adr_wb; m_fwd_data = e_data;
            end
            if (retire_wb && !stall && !rst_pipe) begin
                m_instret = m_instret + 1;
                m_small = (m_small + 1) % 8;
            end
        end
        @(posedge clk);
        #1;
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, m_fwd_valid});
        chk("fwd_adr", {59'd0, fwd_adr}, {59'd0, m_fwd_adr});
        chk("fwd_data", {32'd0, fwd_data}, {32'd0, m_fwd_data});
        chk("instret", instret, m_instret);
        chk("small_instret", {61'd0, s_instret}, 64'(m_small));
    endtask

    initial begin
        m_fwd_valid = 1'b0; m_fwd_adr = 5'd0; m_fwd_data = 32'd0;
        m_instret = 64'd0; m_small = 0;

        // Reset held with a writing, retiring instruction present.
        drive(1'b0, 3'b000, 5'd3, 32'h55, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        cycle();
        chk("reset_wbk_en", {63'd0, wbk_en}, 64'd0);
        chk("reset_instret", instret, 64'd0);
        chk("reset_fwd_valid", {63'd0, fwd_valid}, 64'd0);

        // LB from the top byte of the word: sign bit set.
        drive(1'b1, 3'b000, 5'd5, 32'h0000_1003, 1'b1, 32'h80FF_7F01, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("lb_data", {32'd0, wbk_data}, 64'hFFFF_FF80);
        chk("lb_fwd_data", {32'd0, fwd_data}, 64'hFFFF_FF80);
        chk("lb_fwd_valid", {63'd0, fwd_valid}, 64'd1);

        // Halfword and word alignment cases.
        drive(1'b1, 3'b101, 5'd6, 32'h0000_2002, 1'b1, 32'h8001_ABCD, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("lhu_data", {32'd0, wbk_data}, 64'h0000_8001);
        drive(1'b1, 3'b001, 5'd7, 32'h0000_2000, 1'b1, 32'h8001_ABCD, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("lh_data", {32'd0, wbk_data}, 64'hFFFF_ABCD);
        drive(1'b1, 3'b010, 5'd8, 32'h0000_2001, 1'b1, 32'h8001_ABCD, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("lw_data", {32'd0, wbk_data}, 64'h8001_ABCD);

        // ALU result to x0: no write, bypass untouched, still retires.
        drive(1'b0, 3'b000, 5'd0, 32'h0000_1234, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("x0_fwd_adr", {59'd0, fwd_adr}, 64'd8);

        // Load held through a three-cycle stall, then released: exactly one write.
        n_writes = 0;
        drive(1'b1, 3'b100, 5'd9, 32'h0000_0001, 1'b1, 32'h1122_3344, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_no_write", 64'(n_writes), 64'd0);
        stall = 1'b0;
        cycle();
        chk("stall_one_write", 64'(n_writes), 64'd1);
        chk("stall_release_data", {32'd0, fwd_data}, 64'h0000_0033);
        retire_wb = 1'b0; wbk_rd_reg_wb = 1'b0;
        cycle();

        // Walk the narrow counter to all-ones; a flush must not advance it, a retire wraps it.
        drive(1'b0, 3'b000, 5'd10, 32'hABCD, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8 && m_small != 7; i++) cycle();
        chk("small_at_max", {61'd0, s_instret}, 64'd7);
        rst_pipe = 1'b1;
        cycle();
        chk("flush_holds_count", {61'd0, s_instret}, 64'd7);
        chk("flush_clears_fwd", {63'd0, fwd_valid}, 64'd0);
        rst_pipe = 1'b0;
        cycle();
        chk("small_wrap", {61'd0, s_instret}, 64'd0);

        // Reset arriving mid-stream.
        drive(1'b0, 3'b000, 5'd11, 32'h77, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("midrst_instret", instret, 64'd0);
        chk("midrst_fwd_valid", {63'd0, fwd_valid}, 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
